// File: rtl/kmeans_pkg.sv
// rtl/kmeans_pkg.sv - shared constants, host FSM encoding and point word layout for the kMeans host
// Contents:
//   CLUSTER_SIZE / DATA_SIZE / FRAME_LEN : frame geometry (seeds, points, words per input burst)
//   IDX_W                                : width of a cluster index
//   ST_*                                 : host FSM state encoding
//   PT_* / point_t                       : point word fields, x in [15:8], y in [7:0]
package kmeans_pkg;

    localparam int CLUSTER_SIZE = 4;
    localparam int DATA_SIZE    = 4096;
    localparam int FRAME_LEN    = CLUSTER_SIZE + DATA_SIZE;
    localparam int IDX_W        = $clog2(CLUSTER_SIZE);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_FETCH = 3'd1;
    localparam logic [2:0] ST_SEND  = 3'd2;
    localparam logic [2:0] ST_WAIT  = 3'd3;
    localparam logic [2:0] ST_CAPT  = 3'd4;
    localparam logic [2:0] ST_DRAIN = 3'd5;

    localparam int PT_X_HI = 15;
    localparam int PT_X_LO = 8;
    localparam int PT_Y_HI = 7;
    localparam int PT_Y_LO = 0;

    typedef struct packed {
        logic [PT_X_HI-PT_X_LO:0] x;
        logic [PT_Y_HI-PT_Y_LO:0] y;
    } point_t;

endpackage

// File: rtl/kmeans_frame_host_if.sv
// rtl/kmeans_frame_host_if.sv - core stream and result drain signals of the kMeans frame host
// Signals:
//   k_in_valid/k_in_data   host -> core input burst
//   k_out_valid/k_out_data core -> host result burst
//   res_valid/res_ready/res_data/res_idx  captured centroids drained upstream
// Modports: master = host side, slave = core + upstream side.
interface kmeans_frame_host_if;
    import kmeans_pkg::*;

    logic             k_in_valid;
    logic [15:0]      k_in_data;
    logic             k_out_valid;
    logic [15:0]      k_out_data;
    logic             res_valid;
    logic             res_ready;
    logic [15:0]      res_data;
    logic [IDX_W-1:0] res_idx;

    modport master (
        output k_in_valid, k_in_data,
        input  k_out_valid, k_out_data,
        output res_valid, res_data, res_idx,
        input  res_ready
    );

    modport slave (
        input  k_in_valid, k_in_data,
        output k_out_valid, k_out_data,
        input  res_valid, res_data, res_idx,
        output res_ready
    );

endinterface

// File: rtl/kmeans_res_buf.sv
// rtl/kmeans_res_buf.sv - CLUSTER_SIZE x 16 result register file with write pointer and valid/ready drain
// Ports:
//   clk, rst_n             clock, synchronous active-low reset
//   clear_i                empties the buffer and rewinds both pointers
//   wr_en_i, wr_data_i     write one word at the write pointer, pointer auto-increments
//   wr_last_o              the next write fills the final slot
//   rd_active_i            drain enabled (drives rd_valid_o)
//   rd_ready_i             consumer accepts the current word
//   rd_valid_o, rd_data_o, rd_idx_o  current word and its slot index
//   rd_last_o              the final slot is handed over this cycle
module kmeans_res_buf
    import kmeans_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear_i,
    input  logic             wr_en_i,
    input  logic [15:0]      wr_data_i,
    output logic             wr_last_o,
    input  logic             rd_active_i,
    input  logic             rd_ready_i,
    output logic             rd_valid_o,
    output logic [15:0]      rd_data_o,
    output logic [IDX_W-1:0] rd_idx_o,
    output logic             rd_last_o
);

    localparam logic [IDX_W-1:0] LAST_SLOT = IDX_W'(CLUSTER_SIZE - 1);

    logic [15:0]      slot_q [CLUSTER_SIZE];
    logic [IDX_W-1:0] wr_ptr_q;
    logic [IDX_W-1:0] rd_ptr_q;
    logic             rd_fire;

    assign rd_fire    = rd_active_i && rd_ready_i;
    assign wr_last_o  = (wr_ptr_q == LAST_SLOT);
    assign rd_valid_o = rd_active_i;
    assign rd_data_o  = slot_q[rd_ptr_q];
    assign rd_idx_o   = rd_ptr_q;
    assign rd_last_o  = rd_fire && (rd_ptr_q == LAST_SLOT);

    // Pointers wrap naturally (power-of-two depth), so a completed
    // capture/drain leaves both at slot 0 for the next frame.
    always_ff @(posedge clk) begin
        if (!rst_n || clear_i) begin
            for (int i = 0; i < CLUSTER_SIZE; i++) begin
                slot_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (wr_en_i) begin
                slot_q[wr_ptr_q] <= wr_data_i;
                wr_ptr_q         <= wr_ptr_q + 1'b1;
            end
            if (rd_fire) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/kmeans_frame_host.sv
// rtl/kmeans_frame_host.sv - fetches a frame from sync RAM, streams it to the kMeans core, captures and drains results
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   start_i           one-cycle request, honoured only in IDLE
//   busy_o            high outside IDLE
//   done_o            pulse during the last result handshake
//   err_o             sticky timeout / short-burst flag, cleared by an accepted start
//   rd_en_o, rd_addr_o, rd_data_i   frame RAM port (1-cycle read latency)
//   bus               master side of kmeans_frame_host_if (core stream + result drain)
module kmeans_frame_host
    import kmeans_pkg::*;
#(
    parameter int ADDR_W   = 13,
    parameter int MAX_WAIT = 33554431,
    parameter int WAIT_W   = 25
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    output logic              rd_en_o,
    output logic [ADDR_W-1:0] rd_addr_o,
    input  logic [15:0]       rd_data_i,
    kmeans_frame_host_if.master bus
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_LEN - 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

    logic [2:0]        state_q, state_d;
    logic              rd_en_q, rd_en_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic              rd_en_dly_q, rd_en_dly_d;
    logic              k_in_valid_q, k_in_valid_d;
    logic [15:0]       k_in_data_q, k_in_data_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              err_q, err_d;

    logic buf_clear, buf_wr, buf_wr_last, buf_rd_last;

    kmeans_res_buf u_res_buf (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear_i    (buf_clear),
        .wr_en_i    (buf_wr),
        .wr_data_i  (bus.k_out_data),
        .wr_last_o  (buf_wr_last),
        .rd_active_i(state_q == ST_DRAIN),
        .rd_ready_i (bus.res_ready),
        .rd_valid_o (bus.res_valid),
        .rd_data_o  (bus.res_data),
        .rd_idx_o   (bus.res_idx),
        .rd_last_o  (buf_rd_last)
    );

    always_comb begin
        state_d     = state_q;
        rd_en_d     = rd_en_q;
        rd_addr_d   = rd_addr_q;
        wait_cnt_d  = wait_cnt_q;
        err_d       = err_q;
        buf_clear   = 1'b0;
        buf_wr      = 1'b0;
        // rd_en_dly lines up with the RAM latency; one more stage registers the word
        // toward the core, so the burst is exactly as long and gap-free as rd_en.
        rd_en_dly_d  = rd_en_q;
        k_in_valid_d = rd_en_dly_q;
        k_in_data_d  = rd_en_dly_q ? rd_data_i : 16'h0000;

        if (rd_en_q) begin
            if (rd_addr_q == LAST_ADDR) begin
                rd_en_d = 1'b0;
            end else begin
                rd_addr_d = rd_addr_q + 1'b1;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d   = ST_FETCH;
                    err_d     = 1'b0;
                    rd_en_d   = 1'b1;
                    rd_addr_d = '0;
                    buf_clear = 1'b1;
                end
            end
            ST_FETCH: state_d = ST_SEND;
            ST_SEND: begin
                // Last word is on the core port and nothing follows it.
                if (k_in_valid_q && !rd_en_dly_q) begin
                    state_d    = ST_WAIT;
                    wait_cnt_d = '0;
                end
            end
            ST_WAIT: begin
                if (bus.k_out_valid) begin
                    buf_wr  = 1'b1;
                    state_d = ST_CAPT;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            ST_CAPT: begin
                if (bus.k_out_valid) begin
                    buf_wr = 1'b1;
                    if (buf_wr_last) begin
                        state_d = ST_DRAIN;
                    end
                end else begin
                    err_d     = 1'b1;
                    buf_clear = 1'b1;
                    state_d   = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                if (buf_rd_last) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            rd_en_q      <= 1'b0;
            rd_addr_q    <= '0;
            rd_en_dly_q  <= 1'b0;
            k_in_valid_q <= 1'b0;
            k_in_data_q  <= '0;
            wait_cnt_q   <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            rd_en_q      <= rd_en_d;
            rd_addr_q    <= rd_addr_d;
            rd_en_dly_q  <= rd_en_dly_d;
            k_in_valid_q <= k_in_valid_d;
            k_in_data_q  <= k_in_data_d;
            wait_cnt_q   <= wait_cnt_d;
            err_q        <= err_d;
        end
    end

    assign busy_o         = (state_q != ST_IDLE);
    assign done_o         = buf_rd_last;
    assign err_o          = err_q;
    assign rd_en_o        = rd_en_q;
    assign rd_addr_o      = rd_addr_q;
    assign bus.k_in_valid = k_in_valid_q;
    assign bus.k_in_data  = k_in_data_q;

endmodule

// File: tb/tb_kmeans_frame_host.sv
// tb/tb_kmeans_frame_host.sv - self-checking bench for kmeans_frame_host
module tb_kmeans_frame_host;
    import kmeans_pkg::*;

    localparam int ADDR_W   = 13;
    localparam int MAX_WAIT = 100;

    typedef struct {
        int               n_resp;
        int               delay;
        logic [3:0]       ready_pat;
        logic [3:0][15:0] res;
        bit               noise;
        int               exp_err;
        int               exp_done;
        int               exp_hs;
        int               exp_end_rel;
    } vec_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic              busy, done, err, rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [15:0]       rd_data = 16'h0000;
    logic [15:0]       ram [FRAME_LEN];
    logic [15:0]       seeds [4];
    vec_t              vecs [4];
    int                tests = 0;
    int                fails = 0;

    kmeans_frame_host_if bus();

    kmeans_frame_host #(.ADDR_W(ADDR_W), .MAX_WAIT(MAX_WAIT)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start_i  (start),
        .busy_o   (busy),
        .done_o   (done),
        .err_o    (err),
        .rd_en_o  (rd_en),
        .rd_addr_o(rd_addr),
        .rd_data_i(rd_data),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rd_en && rd_addr < FRAME_LEN) rd_data <= ram[rd_addr];
    end

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_busy_done_err"}, {busy, done, err}, 0);
        chk({tag, "_rd_en_addr"}, {rd_en, rd_addr}, 0);
        chk({tag, "_k_in"}, {bus.k_in_valid, bus.k_in_data}, 0);
        chk({tag, "_res_valid"}, bus.res_valid, 0);
    endtask

    // Called at 2 time units after an edge; start is sampled at the next edge (cycle 0).
    task automatic run_frame(input vec_t s, input string tag);
        int first_v = -1, fall = -1, end_cyc = -1, done_cyc = -1;
        int vcnt = 0, gaps = 0, dmis = 0, seedmis = 0, rd_en_cnt = 0, max_addr = 0;
        int hs = 0, rmis = 0, stall_bad = 0, done_cnt = 0, drain_cyc = 0, rv_cnt = 0;
        logic prev_v = 1'b0, prev_rv = 1'b0, prev_rr = 1'b0;
        logic [15:0] prev_rd = '0;
        logic [IDX_W-1:0] prev_ri = '0;
        int j;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        #1;
        chk({tag, "_err_cleared_busy"}, {err, busy}, 1);
        if (rd_en) begin rd_en_cnt++; max_addr = rd_addr; end
        for (int cyc = 1; cyc <= 4600; cyc++) begin
            @(posedge clk); #1;
            start = (s.noise && cyc == 50);
            j = (fall >= 0) ? cyc - fall - s.delay : -1;
            bus.k_out_valid = (j >= 0 && j < s.n_resp) || (s.noise && cyc >= 100 && cyc < 103);
            bus.k_out_data  = (j >= 0 && j < s.n_resp) ? s.res[j] : 16'hDEAD;
            bus.res_ready   = s.ready_pat[drain_cyc % 4];
            #1;
            if (rd_en) begin
                rd_en_cnt++;
                if (int'(rd_addr) > max_addr) max_addr = rd_addr;
            end
            if (bus.k_in_valid) begin
                if (first_v < 0) first_v = cyc;
                else if (!prev_v) gaps++;
                if (vcnt >= FRAME_LEN || bus.k_in_data != ram[vcnt]) dmis++;
                if (vcnt < 4 && bus.k_in_data != seeds[vcnt]) seedmis++;
                vcnt++;
            end else begin
                if (bus.k_in_data != 16'h0000) dmis++;
                if (prev_v && fall < 0) fall = cyc;
            end
            if (bus.res_valid) begin
                rv_cnt++;
                if (prev_rv && !prev_rr && (bus.res_data != prev_rd || bus.res_idx != prev_ri)) stall_bad++;
                if (bus.res_ready) begin
                    if (hs >= 4 || int'(bus.res_idx) != hs || bus.res_data != s.res[hs]) rmis++;
                    hs++;
                end
                drain_cyc++;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                if (!(bus.res_valid && bus.res_ready && hs == 4)) rmis++;
            end
            prev_v  = bus.k_in_valid;
            prev_rv = bus.res_valid;
            prev_rr = bus.res_ready;
            prev_rd = bus.res_data;
            prev_ri = bus.res_idx;
            if (!busy) begin
                end_cyc = cyc;
                break;
            end
        end
        bus.k_out_valid = 1'b0;
        bus.res_ready   = 1'b0;
        chk({tag, "_frame_ended"}, (end_cyc >= 0), 1);
        chk({tag, "_first_valid_cycle"}, first_v, 2);
        chk({tag, "_burst_len"}, vcnt, FRAME_LEN);
        chk({tag, "_burst_gaps"}, gaps, 0);
        chk({tag, "_seed_words"}, seedmis, 0);
        chk({tag, "_stream_data"}, dmis, 0);
        chk({tag, "_rd_en_cycles"}, rd_en_cnt, FRAME_LEN);
        chk({tag, "_max_rd_addr"}, max_addr, FRAME_LEN - 1);
        chk({tag, "_err"}, err, s.exp_err);
        chk({tag, "_done_pulses"}, done_cnt, s.exp_done);
        chk({tag, "_handshakes"}, hs, s.exp_hs);
        chk({tag, "_res_valid_cycles_min"}, (rv_cnt >= s.exp_hs), 1);
        chk({tag, "_result_words"}, rmis, 0);
        chk({tag, "_stall_stable"}, stall_bad, 0);
        if (s.exp_done != 0) chk({tag, "_idle_after_done"}, end_cyc, done_cyc + 1);
        else                 chk({tag, "_end_latency"}, end_cyc - fall, s.exp_end_rel);
    endtask

    initial begin
        int vc;
        seeds[0] = 16'h1010; seeds[1] = 16'h10F0; seeds[2] = 16'hF010; seeds[3] = 16'hF0F0;
        for (int i = 0; i < FRAME_LEN; i++) begin
            ram[i] = (i < 4) ? seeds[i] : 16'(i * 97 + 13);
        end

        vecs[0] = '{n_resp: 4, delay: 3, ready_pat: 4'b1111,
                    res: {16'hE0E0, 16'hE020, 16'h20E0, 16'h2020}, noise: 1'b0,
                    exp_err: 0, exp_done: 1, exp_hs: 4, exp_end_rel: 0};
        vecs[1] = '{n_resp: 4, delay: 5, ready_pat: 4'b1001,
                    res: {16'h4444, 16'h3333, 16'h2222, 16'h1111}, noise: 1'b1,
                    exp_err: 0, exp_done: 1, exp_hs: 4, exp_end_rel: 0};
        vecs[2] = '{n_resp: 0, delay: 3, ready_pat: 4'b1111,
                    res: {16'h0, 16'h0, 16'h0, 16'h0}, noise: 1'b0,
                    exp_err: 1, exp_done: 0, exp_hs: 0, exp_end_rel: MAX_WAIT};
        vecs[3] = '{n_resp: 2, delay: 3, ready_pat: 4'b1111,
                    res: {16'h0, 16'h0, 16'hABCD, 16'h1234}, noise: 1'b0,
                    exp_err: 1, exp_done: 0, exp_hs: 0, exp_end_rel: 6};

        rst_n = 1'b0;
        start = 1'b1;
        bus.k_out_valid = 1'b0;
        bus.k_out_data  = 16'h0000;
        bus.res_ready   = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check_reset_vals("reset");
        start = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #2;

        for (int v = 0; v < 4; v++) begin
            run_frame(vecs[v], $sformatf("vec%0d", v));
            @(posedge clk); #2;
        end

        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        #1;
        vc = 0;
        for (int g = 0; g < 3000 && vc < 2000; g++) begin
            @(posedge clk); #2;
            if (bus.k_in_valid) vc++;
        end
        chk("mid_send_reached", vc, 2000);
        rst_n = 1'b0;
        @(posedge clk); #2;
        check_reset_vals("mid_reset");
        rst_n = 1'b1;
        @(posedge clk); #2;
        run_frame(vecs[0], "after_reset");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
